// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads; default build uses a registered 1-cycle read.
module fifo_buffer_param #(
    parameter int DATA_SIZE  = 6,
    parameter int ADDR_SIZE  = 3,
    parameter int AFULL_THR  = 6,
    parameter int AEMPTY_THR = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   fifo_count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_CNT  = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE + 1)'(AFULL_THR);
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE + 1)'(AEMPTY_THR);

    if (AFULL_THR > DEPTH || AEMPTY_THR >= DEPTH) begin : g_bad_thr
        $error("fifo_buffer_param: AFULL_THR must be <= DEPTH and AEMPTY_THR < DEPTH");
    end

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   count_q;
    logic                 rd_acc;
    logic                 wr_acc;

    // A pop frees a slot in the same edge, so a full FIFO can still take a write alongside it.
    assign rd_acc = read & ~empty;
    assign wr_acc = write & (~full | rd_acc);

    assign fifo_count   = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_CNT);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow  <= write & ~wr_acc;
            underflow <= read & empty;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out  = empty ? '0 : mem[rd_ptr];
    assign valid_out = ~empty;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (rd_acc) begin
            data_out  <= mem[rd_ptr];
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Self-checking bench for fifo_buffer_param: directed scenarios plus random traffic against a queue model.
// Honours FIFO_FWFT_EN so the same bench covers both read modes.
module tb_fifo_buffer_param;

    localparam int DATA_SIZE  = 6;
    localparam int ADDR_SIZE  = 3;
    localparam int AFULL_THR  = 6;
    localparam int AEMPTY_THR = 1;
    localparam int DEPTH      = 2 ** ADDR_SIZE;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 write;
    logic [DATA_SIZE-1:0] data_in;
    logic                 read;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 overflow;
    logic                 underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int unsigned q[$];
    int unsigned exp_data  = 0;
    int unsigned exp_valid = 0;
    int unsigned exp_ovf   = 0;
    int unsigned exp_udf   = 0;

    fifo_buffer_param #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .AFULL_THR (AFULL_THR),
        .AEMPTY_THR(AEMPTY_THR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .data_in     (data_in),
        .read        (read),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string scen);
        int unsigned sz;
        int unsigned ev;
        int unsigned ed;
        sz = q.size();
`ifdef FIFO_FWFT_EN
        ev = (sz > 0) ? 1 : 0;
        ed = (sz > 0) ? q[0] : 0;
`else
        ev = exp_valid;
        ed = exp_data;
`endif
        chk({scen, ".count"},  fifo_count,   sz);
        chk({scen, ".empty"},  empty,        (sz == 0) ? 1 : 0);
        chk({scen, ".full"},   full,         (sz == DEPTH) ? 1 : 0);
        chk({scen, ".afull"},  almost_full,  (sz >= AFULL_THR) ? 1 : 0);
        chk({scen, ".aempty"}, almost_empty, (sz <= AEMPTY_THR) ? 1 : 0);
        chk({scen, ".ovf"},    overflow,     exp_ovf);
        chk({scen, ".udf"},    underflow,    exp_udf);
        chk({scen, ".valid"},  valid_out,    ev);
        chk({scen, ".data"},   data_out,     ed);
    endtask

    // One clock: drive on the falling edge, advance the model, check just after the rising edge.
    task automatic step(input string scen, input logic w, input int unsigned d,
                        input logic r, input logic rst);
        bit rd_ok;
        bit wr_ok;
        @(negedge clk);
        write   = w;
        data_in = DATA_SIZE'(d);
        read    = r;
        reset   = rst;
        if (rst) begin
            q.delete();
            exp_data  = 0;
            exp_valid = 0;
            exp_ovf   = 0;
            exp_udf   = 0;
        end else begin
            rd_ok   = r && (q.size() > 0);
            wr_ok   = w && ((q.size() < DEPTH) || rd_ok);
            exp_ovf = (w && !wr_ok) ? 1 : 0;
            exp_udf = (r && q.size() == 0) ? 1 : 0;
            if (rd_ok) begin
                exp_data  = q.pop_front();
                exp_valid = 1;
            end else begin
                exp_valid = 0;
            end
            if (wr_ok) q.push_back(d & ((1 << DATA_SIZE) - 1));
        end
        @(posedge clk);
        #1;
        check_all(scen);
    endtask

    initial begin
        reset   = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = '0;

        // 1. reset then idle
        step("rst", 0, 0, 0, 1);
        step("rst", 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0);

        // 2. fill, overflow, drain
        for (int i = 1; i <= 8; i++) step("fill", 1, i, 0, 0);
        step("ovf", 1, 'h3F, 0, 0);
        step("ovf_end", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("drain", 0, 0, 1, 0);
        step("drain_end", 0, 0, 0, 0);

        // 3. pointer wrap
        for (int i = 0; i < 5; i++) step("wrap_w5", 1, 'h10 + i, 0, 0);
        for (int i = 0; i < 5; i++) step("wrap_r5", 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step("wrap_w6", 1, 'h20 + i, 0, 0);
        for (int i = 0; i < 6; i++) step("wrap_r6", 0, 0, 1, 0);
        step("wrap_end", 0, 0, 0, 0);

        // 4. full + read + write
        for (int i = 0; i < 8; i++) step("full_fill", 1, 'h30 + i, 0, 0);
        step("full_rw", 1, 'h2A, 1, 0);
        for (int i = 0; i < 8; i++) step("full_drain", 0, 0, 1, 0);
        step("full_end", 0, 0, 0, 0);

        // 5. empty + read + write
        step("empty_rw", 1, 'h15, 1, 0);
        step("empty_rd", 0, 0, 1, 0);
        step("empty_end", 0, 0, 0, 0);

        // 6. reset mid-burst
        for (int i = 0; i < 4; i++) step("burst", 1, 'h05 + i, (i > 1), 0);
        step("burst_rst", 1, 'h3C, 1, 1);
        step("post_rst", 0, 0, 0, 0);

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (i / 200) % 2 == 0 ? 70 : 35;
            rp = 100 - wp;
            step("rand", ($urandom_range(99) < wp), $urandom_range(63),
                 ($urandom_range(99) < rp), ($urandom_range(299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected end before 500000");
        $fatal(1, "timeout");
    end

endmodule
